// File: rtl/count_1596_decoder.sv
// Observer for an up/down counter sample stream: classifies each sample step,
// flags wraps and jumps, and keeps saturating direction totals and a stall flag.
module count_1596_decoder #(
  parameter int W         = 10,
  parameter int CW        = 16,
  parameter int STALL_LIM = 8
) (
  input  logic          clk5m,
  input  logic          rst,
  input  logic          smp_vld,
  input  logic [W-1:0]  cnt_in,
  input  logic          clr_stats,
  output logic [1:0]    state,
  output logic          ev_up,
  output logic          ev_dn,
  output logic          ev_hold,
  output logic          ev_jump,
  output logic          wrap_up,
  output logic          wrap_dn,
  output logic [W-1:0]  jump_val,
  output logic [CW-1:0] up_total,
  output logic [CW-1:0] dn_total,
  output logic          stalled
);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_UP   = 2'd2;
  localparam logic [1:0] ST_DN   = 2'd3;

  localparam logic [W-1:0]  ONE_W     = W'(1);
  localparam logic [W-1:0]  ALL_W     = '1;
  localparam logic [CW-1:0] SAT_CW    = '1;
  localparam logic [7:0]    STALL_THR = 8'(STALL_LIM);

  // Strobe semantics: smp_vld has no ready/back-pressure; every clk5m edge with
  // smp_vld=1 consumes cnt_in, and edges with smp_vld=0 leave all state untouched.

  logic [W-1:0] prev;
  logic [7:0]   hold_run;
  logic [W-1:0] d;
  logic         classify;
  logic         is_hold, is_up, is_dn, is_jump;

  logic [1:0]    state_nxt;
  logic [7:0]    hold_run_nxt;
  logic [CW-1:0] up_total_nxt, dn_total_nxt;

  assign d        = cnt_in - prev;
  assign classify = smp_vld && (state != ST_INIT);
  assign is_hold  = classify && (d == '0);
  assign is_up    = classify && (d == ONE_W);
  assign is_dn    = classify && (d == ALL_W);
  assign is_jump  = classify && !is_hold && !is_up && !is_dn;

  always_comb begin
    state_nxt = state;
    if (smp_vld) begin
      if (state == ST_INIT)  state_nxt = ST_HOLD;
      else if (is_up)        state_nxt = ST_UP;
      else if (is_dn)        state_nxt = ST_DN;
      else                   state_nxt = ST_HOLD;
    end
  end

  // Clear beats any increment on the same edge; the pulses are unaffected.
  always_comb begin
    hold_run_nxt = hold_run;
    up_total_nxt = up_total;
    dn_total_nxt = dn_total;
    if (clr_stats) begin
      hold_run_nxt = '0;
      up_total_nxt = '0;
      dn_total_nxt = '0;
    end else begin
      if (is_hold) begin
        if (hold_run != 8'hff) hold_run_nxt = hold_run + 8'd1;
      end else if (classify) begin
        hold_run_nxt = '0;
      end
      if (is_up && up_total != SAT_CW) up_total_nxt = up_total + CW'(1);
      if (is_dn && dn_total != SAT_CW) dn_total_nxt = dn_total + CW'(1);
    end
  end

  always_ff @(posedge clk5m) begin
    if (rst) begin
      state    <= ST_INIT;
      prev     <= '0;
      hold_run <= '0;
      ev_up    <= 1'b0;
      ev_dn    <= 1'b0;
      ev_hold  <= 1'b0;
      ev_jump  <= 1'b0;
      wrap_up  <= 1'b0;
      wrap_dn  <= 1'b0;
      jump_val <= '0;
      up_total <= '0;
      dn_total <= '0;
      stalled  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_run <= hold_run_nxt;
      up_total <= up_total_nxt;
      dn_total <= dn_total_nxt;
      stalled  <= (hold_run_nxt >= STALL_THR);
      ev_up    <= is_up;
      ev_dn    <= is_dn;
      ev_hold  <= is_hold;
      ev_jump  <= is_jump;
      wrap_up  <= is_up && (prev == ALL_W);
      wrap_dn  <= is_dn && (prev == '0);
      if (smp_vld) prev     <= cnt_in;
      if (is_jump) jump_val <= cnt_in;
    end
  end

endmodule

// File: tb/tb_count_1596_decoder.sv
// Directed bench for count_1596_decoder: linear sample sequence with
// hand-computed expectations checked by immediate assertions.
module tb_count_1596_decoder;

  localparam int W  = 10;
  localparam int CW = 16;

  logic          clk5m = 1'b0;
  logic          rst, smp_vld, clr_stats;
  logic [W-1:0]  cnt_in;
  logic [1:0]    state;
  logic          ev_up, ev_dn, ev_hold, ev_jump, wrap_up, wrap_dn, stalled;
  logic [W-1:0]  jump_val;
  logic [CW-1:0] up_total, dn_total;

  int errors = 0;
  int checks = 0;

  count_1596_decoder #(.W(W), .CW(CW), .STALL_LIM(8)) dut (
    .clk5m(clk5m), .rst(rst), .smp_vld(smp_vld), .cnt_in(cnt_in),
    .clr_stats(clr_stats), .state(state), .ev_up(ev_up), .ev_dn(ev_dn),
    .ev_hold(ev_hold), .ev_jump(ev_jump), .wrap_up(wrap_up), .wrap_dn(wrap_dn),
    .jump_val(jump_val), .up_total(up_total), .dn_total(dn_total),
    .stalled(stalled)
  );

  always #100 clk5m = ~clk5m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ev vector is {up, dn, hold, jump}; wraps are {wrap_up, wrap_dn}.
  task automatic chk_out(input string tag, input logic [3:0] ev, input logic [1:0] wr,
                         input logic [1:0] st, input int upt, input int dnt, input logic stl);
    chk({tag, ".ev"},    {28'd0, ev_up, ev_dn, ev_hold, ev_jump}, {28'd0, ev});
    chk({tag, ".wrap"},  {30'd0, wrap_up, wrap_dn}, {30'd0, wr});
    chk({tag, ".state"}, {30'd0, state}, {30'd0, st});
    chk({tag, ".up"},    {16'd0, up_total}, upt);
    chk({tag, ".dn"},    {16'd0, dn_total}, dnt);
    chk({tag, ".stall"}, {31'd0, stalled}, {31'd0, stl});
  endtask

  // Drive one edge; outputs are sampled 1 time unit after it.
  task automatic step(input logic vld, input int v, input logic clr);
    @(negedge clk5m);
    smp_vld   = vld;
    cnt_in    = W'(v);
    clr_stats = clr;
    @(posedge clk5m);
    #1;
    smp_vld   = 1'b0;
    clr_stats = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst = 1'b1; smp_vld = 1'b0; clr_stats = 1'b0; cnt_in = '0;
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    rst = 1'b0;
    chk_out("reset", 4'b0000, 2'b00, 2'd0, 0, 0, 1'b0);
    chk("reset.jv", {22'd0, jump_val}, 0);

    step(1'b1, 5, 1'b0); chk_out("s5",  4'b0000, 2'b00, 2'd1, 0, 0, 1'b0);
    step(1'b1, 6, 1'b0); chk_out("s6",  4'b1000, 2'b00, 2'd2, 1, 0, 1'b0);
    step(1'b1, 7, 1'b0); chk_out("s7",  4'b1000, 2'b00, 2'd2, 2, 0, 1'b0);
    step(1'b1, 8, 1'b0); chk_out("s8",  4'b1000, 2'b00, 2'd2, 3, 0, 1'b0);

    step(1'b1, 1022, 1'b0); chk_out("s1022", 4'b0001, 2'b00, 2'd1, 3, 0, 1'b0);
    chk("s1022.jv", {22'd0, jump_val}, 1022);
    step(1'b1, 1023, 1'b0); chk_out("s1023", 4'b1000, 2'b00, 2'd2, 4, 0, 1'b0);
    step(1'b1, 0, 1'b0);    chk_out("wrapu", 4'b1000, 2'b10, 2'd2, 5, 0, 1'b0);
    step(1'b1, 1, 1'b0);    chk_out("s1",    4'b1000, 2'b00, 2'd2, 6, 0, 1'b0);
    step(1'b1, 0, 1'b0);    chk_out("dn0",   4'b0100, 2'b00, 2'd3, 6, 1, 1'b0);
    step(1'b1, 1023, 1'b0); chk_out("wrapd", 4'b0100, 2'b01, 2'd3, 6, 2, 1'b0);

    step(1'b1, 10, 1'b0);   chk_out("j10",   4'b0001, 2'b00, 2'd1, 6, 2, 1'b0);
    step(1'b1, 11, 1'b0);   chk_out("s11",   4'b1000, 2'b00, 2'd2, 7, 2, 1'b0);
    step(1'b1, 1023, 1'b0); chk_out("j1023", 4'b0001, 2'b00, 2'd1, 7, 2, 1'b0);
    chk("j1023.jv", {22'd0, jump_val}, 1023);

    step(1'b1, 300, 1'b0);  chk_out("j300", 4'b0001, 2'b00, 2'd1, 7, 2, 1'b0);
    chk("j300.jv", {22'd0, jump_val}, 300);
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, 300, 1'b0);
      chk_out("hold", 4'b0010, 2'b00, 2'd1, 7, 2, 1'b0);
    end
    step(1'b1, 300, 1'b0);  chk_out("hold8", 4'b0010, 2'b00, 2'd1, 7, 2, 1'b1);
    step(1'b1, 301, 1'b0);  chk_out("s301",  4'b1000, 2'b00, 2'd2, 8, 2, 1'b0);

    step(1'b1, 4, 1'b0);    chk_out("j4",  4'b0001, 2'b00, 2'd1, 8, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 999, 1'b0);
      chk_out("gap", 4'b0000, 2'b00, 2'd1, 8, 2, 1'b0);
    end
    step(1'b1, 5, 1'b0);    chk_out("g5",  4'b1000, 2'b00, 2'd2, 9, 2, 1'b0);
    step(1'b1, 6, 1'b1);    chk_out("clr6", 4'b1000, 2'b00, 2'd2, 0, 0, 1'b0);

    // Seven holds, a gap, then one more hold must reach the limit exactly.
    for (int i = 0; i < 7; i++) step(1'b1, 6, 1'b0);
    chk_out("h7", 4'b0010, 2'b00, 2'd1, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 6, 1'b0);
    chk_out("h7gap", 4'b0000, 2'b00, 2'd1, 0, 0, 1'b0);
    step(1'b1, 6, 1'b0);    chk_out("h8", 4'b0010, 2'b00, 2'd1, 0, 0, 1'b1);
    step(1'b0, 6, 1'b1);    chk_out("clrstall", 4'b0000, 2'b00, 2'd1, 0, 0, 1'b0);

    for (int v = 7; v <= 26; v++) step(1'b1, v, 1'b0);
    chk_out("up20", 4'b1000, 2'b00, 2'd2, 20, 0, 1'b0);

    rst = 1'b1;
    step(1'b1, 27, 1'b1);
    rst = 1'b0;
    chk_out("midrst", 4'b0000, 2'b00, 2'd0, 0, 0, 1'b0);
    chk("midrst.jv", {22'd0, jump_val}, 0);
    step(1'b1, 28, 1'b0);   chk_out("post28", 4'b0000, 2'b00, 2'd1, 0, 0, 1'b0);
    step(1'b1, 29, 1'b0);   chk_out("post29", 4'b1000, 2'b00, 2'd2, 1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_1596_decoder.md
# count_1596_decoder

Observer for the 10-bit up/down counter value stream on `clk5m`. It samples the counter output and reconstructs what the counter did each sample: count up, count down, hold, or load (jump). It also flags wrap-around, keeps saturating up/down totals and flags a stalled counter. It sits downstream of the counter as the reading end of the `cnt` bus, for status reporting and self-checking.

## Interface
- `W`, 10, counter/sample width; arithmetic is modulo 2^W
- `CW`, 16, width of the up/down event totals
- `STALL_LIM`, 8, number of consecutive HOLD events that asserts `stalled` (1..255)

- `clk5m` in 1: single clock, all logic on its rising edge
- `rst` in 1: synchronous reset, active-high
- `smp_vld` in 1: `cnt_in` is sampled on this edge
- `cnt_in` in W: counter value being observed
- `clr_stats` in 1: synchronous clear of the totals, `hold_run` and `stalled`
- `state` out 2: tracker state; INIT=0, HOLD=1, UP=2, DN=3
- `ev_up`, `ev_dn`, `ev_hold`, `ev_jump` out 1: one-cycle event pulses, mutually exclusive
- `wrap_up` out 1: one-cycle pulse, UP step from 2^W-1 to 0
- `wrap_dn` out 1: one-cycle pulse, DN step from 0 to 2^W-1
- `jump_val` out W: `cnt_in` captured at the last JUMP event
- `up_total`, `dn_total` out CW: saturating event counts
- `stalled` out 1: level, HOLD run length >= STALL_LIM

## Operation
- Internal registers: `prev` (W bits) and `hold_run` (8 bits, saturating at 255).
- Step classification on a sample edge (`smp_vld`=1, `state`≠INIT): `d = (cnt_in - prev) mod 2^W`.
  - d=0 → HOLD
  - d=1 → UP; if `prev`=2^W-1, also `wrap_up`
  - d=2^W-1 → DN; if `prev`=0, also `wrap_dn`
  - any other d → JUMP; `jump_val` ← `cnt_in`
- Every sample edge loads `prev` ← `cnt_in`.
- State transitions:
  - INIT + sample → HOLD. No event pulse and no stats change; only `prev` loads.
  - From HOLD/UP/DN: HOLD event → HOLD, UP → UP, DN → DN.
  - JUMP event → HOLD, because direction is unknown after a load.
- Totals:
  - `up_total`+1 on UP, `dn_total`+1 on DN.
  - Both saturate at 2^CW-1 and never wrap.
- Stall tracking:
  - `hold_run`+1 on a HOLD event; cleared to 0 on an UP, DN or JUMP event.
  - `stalled` = (`hold_run` >= STALL_LIM), registered.
- `smp_vld`=0: all registers hold and all pulses are 0. Gaps do not count as HOLD.
- `clr_stats`=1:
  - Clears `up_total`, `dn_total`, `hold_run` and `stalled`.
  - Does not affect `state`, `prev`, `jump_val` or the pulses.
  - When it coincides with a sample, the event pulse still fires, but clear wins over the increment (totals read 0).
- Reset (`rst`=1, any time, including mid-run):
  - `state`=INIT, all pulses 0, `jump_val`=0, totals 0, `stalled`=0, `prev`=0, `hold_run`=0.
  - The first sample after reset is reference-only.

## Timing
- All outputs are registered.
- Event pulses, wrap pulses, `state`, `jump_val`, totals and `stalled` update on the same edge that samples `cnt_in`. They are visible during the following cycle.
- Latency is 1 clock from `cnt_in` to the outputs.
- Pulses are exactly 1 cycle wide. Back-to-back samples give back-to-back pulses, with no dead cycle.
- `stalled` rises on the edge of the STALL_LIM-th consecutive HOLD event. It falls on the edge of the first non-HOLD event, or on `clr_stats`/`rst`.
- `rst` takes priority over `smp_vld` and `clr_stats` on the same edge.

## Test plan
- Reset, then sample 5,6,7,8 with `smp_vld` every cycle:
  - First sample gives `state` INIT→HOLD and no pulse.
  - Then `ev_up` ×3, `state`=UP, `up_total`=3, `dn_total`=0.
- Sample 1022,1023,0,1,0,1023:
  - `ev_up` on 1023 and on 0, with `wrap_up` on the 0 sample.
  - `ev_up` on 1.
  - `ev_dn` on the second 0, then `ev_dn` plus `wrap_dn` on 1023.
  - Ends with `state`=DN.
- Sample 10,11,1023 (load-like jump):
  - `ev_jump`=1, `jump_val`=1023, `state`=HOLD, totals unchanged by the jump.
- Sample 300 then 300 ×8 with STALL_LIM=8:
  - `stalled` rises on the 8th HOLD event.
  - A following sample of 301 gives `ev_up` and `stalled`=0 on the same edge.
- Sample pattern 4,5 with `smp_vld`=0 for 3 cycles in between:
  - No pulses during the gap, `hold_run` unchanged.
  - Sample 5 gives `ev_up`.
  - `clr_stats` on the same edge as a sample of 6: `ev_up` pulses, `up_total` reads 0.
- `rst` asserted mid UP run at `up_total`=20:
  - Next cycle `state`=INIT and all outputs 0.
  - The first post-reset sample produces no event.
